// File: rtl/mem_loader_if.sv
// Host command/response streams plus the cpu external-memory ports, all driven by mem_loader.
// master = loader side, slave = host and cpu side.
interface mem_loader_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [31:0] cmd_data;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data;
    logic        busy;
    logic        cpu_enable;
    logic [31:0] addr_ext;
    logic [31:0] wdata_ext;
    logic        wen_ext;
    logic        ren_ext;
    logic [31:0] addr_ext_2;
    logic [31:0] wdata_ext_2;
    logic        wen_ext_2;
    logic        ren_ext_2;
    logic [31:0] rdata_ext_2;

    modport master (
        input  cmd_valid, cmd_data, rsp_ready, rdata_ext_2,
        output cmd_ready, rsp_valid, rsp_data, busy, cpu_enable,
               addr_ext, wdata_ext, wen_ext, ren_ext,
               addr_ext_2, wdata_ext_2, wen_ext_2, ren_ext_2
    );

    modport slave (
        output cmd_valid, cmd_data, rsp_ready, rdata_ext_2,
        input  cmd_ready, rsp_valid, rsp_data, busy, cpu_enable,
               addr_ext, wdata_ext, wen_ext, ren_ext,
               addr_ext_2, wdata_ext_2, wen_ext_2, ren_ext_2
    );
endinterface

// File: rtl/mem_loader.sv
// Loads imem/dmem from a header+payload stream, runs the cpu N cycles, dumps dmem words on rsp (optional MEM_LOADER_CHECKSUM_EN adds a burst-sum word).
// Write strobe 1 cycle after accept; dump >= 3 cycles/word; rsp held until rsp_ready, cmd stalled outside HDR/WR.
module mem_loader #(
    parameter int IMEM_WORDS = 512,
    parameter int DMEM_WORDS = 1024
) (
    input  logic         clk,
    input  logic         arst,
    mem_loader_if.master bus
);

    localparam logic [1:0] OP_WR_IMEM = 2'b00;
    localparam logic [1:0] OP_WR_DMEM = 2'b01;
    localparam logic [1:0] OP_RUN     = 2'b10;
    localparam logic [1:0] OP_DUMP    = 2'b11;

    localparam logic [16:0] IMEM_DEPTH = 17'(IMEM_WORDS);
    localparam logic [16:0] DMEM_DEPTH = 17'(DMEM_WORDS);
    localparam logic [15:0] IMEM_LAST  = 16'(IMEM_WORDS - 1);
    localparam logic [15:0] DMEM_LAST  = 16'(DMEM_WORDS - 1);

    typedef enum logic [2:0] {
        S_HDR,
        S_WR,
        S_RUN,
        S_RD,
        S_CAP,
        S_OUT
`ifdef MEM_LOADER_CHECKSUM_EN
        ,
        S_CSUM
`endif
    } state_t;

    function automatic logic [15:0] wrap_start(input logic [15:0] idx, input logic [16:0] depth);
        return 16'({1'b0, idx} % depth);
    endfunction

    function automatic logic [15:0] wrap_next(input logic [15:0] idx, input logic [15:0] last);
        return (idx == last) ? 16'd0 : idx + 16'd1;
    endfunction

    function automatic logic [31:0] word_addr(input logic [15:0] idx);
        return {14'd0, idx, 2'b00};
    endfunction

    state_t      state_q, state_d;
    logic [1:0]  op_q, op_d;
    logic [13:0] cnt_q, cnt_d;
    // Word index for memory ops; reused as the remaining-cycle counter in RUN.
    logic [15:0] idx_q, idx_d;
    logic        cpu_en_q, cpu_en_d;
    logic        imem_wen_q, imem_wen_d;
    logic [31:0] imem_addr_q, imem_addr_d;
    logic [31:0] imem_wdat_q, imem_wdat_d;
    logic        dmem_wen_q, dmem_wen_d;
    logic        dmem_ren_q, dmem_ren_d;
    logic [31:0] dmem_addr_q, dmem_addr_d;
    logic [31:0] dmem_wdat_q, dmem_wdat_d;
    logic        rsp_vld_q, rsp_vld_d;
    logic [31:0] rsp_dat_q, rsp_dat_d;
`ifdef MEM_LOADER_CHECKSUM_EN
    logic [31:0] sum_q, sum_d;
`endif

    logic [1:0]  hdr_op;
    logic [13:0] hdr_cnt;
    logic [15:0] hdr_idx;
    logic        cmd_rdy;
    logic        cmd_fire;
    logic [15:0] imem_start;
    logic [15:0] dmem_start;
    logic [15:0] wr_last;

    assign hdr_op     = bus.cmd_data[31:30];
    assign hdr_cnt    = bus.cmd_data[29:16];
    assign hdr_idx    = bus.cmd_data[15:0];
    assign imem_start = wrap_start(hdr_idx, IMEM_DEPTH);
    assign dmem_start = wrap_start(hdr_idx, DMEM_DEPTH);
    assign wr_last    = (op_q == OP_WR_IMEM) ? IMEM_LAST : DMEM_LAST;

    // Gated by arst so the host sees not-ready during reset yet ready as soon as it releases.
    assign cmd_rdy  = ~arst & ((state_q == S_HDR) | (state_q == S_WR));
    assign cmd_fire = bus.cmd_valid & cmd_rdy;

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        cpu_en_d    = 1'b0;
        imem_wen_d  = 1'b0;
        imem_addr_d = imem_addr_q;
        imem_wdat_d = imem_wdat_q;
        dmem_wen_d  = 1'b0;
        dmem_ren_d  = 1'b0;
        dmem_addr_d = dmem_addr_q;
        dmem_wdat_d = dmem_wdat_q;
        rsp_vld_d   = rsp_vld_q;
        rsp_dat_d   = rsp_dat_q;
`ifdef MEM_LOADER_CHECKSUM_EN
        sum_d       = sum_q;
`endif

        case (state_q)
            S_HDR: begin
                if (cmd_fire) begin
                    op_d  = hdr_op;
                    cnt_d = hdr_cnt;
`ifdef MEM_LOADER_CHECKSUM_EN
                    sum_d = 32'd0;
`endif
                    case (hdr_op)
                        OP_WR_IMEM: begin
                            idx_d = imem_start;
                            if (hdr_cnt != 14'd0) state_d = S_WR;
                        end
                        OP_WR_DMEM: begin
                            idx_d = dmem_start;
                            if (hdr_cnt != 14'd0) state_d = S_WR;
                        end
                        OP_RUN: begin
                            idx_d = hdr_idx;
                            if (hdr_idx != 16'd0) begin
                                state_d  = S_RUN;
                                cpu_en_d = 1'b1;
                            end
                        end
                        OP_DUMP: begin
                            idx_d = dmem_start;
                            if (hdr_cnt != 14'd0) begin
                                state_d     = S_RD;
                                dmem_ren_d  = 1'b1;
                                dmem_addr_d = word_addr(dmem_start);
                            end
                        end
                    endcase
                end
            end

            S_WR: begin
                if (cmd_fire) begin
                    if (op_q == OP_WR_IMEM) begin
                        imem_wen_d  = 1'b1;
                        imem_addr_d = word_addr(idx_q);
                        imem_wdat_d = bus.cmd_data;
                    end else begin
                        dmem_wen_d  = 1'b1;
                        dmem_addr_d = word_addr(idx_q);
                        dmem_wdat_d = bus.cmd_data;
                    end
                    idx_d = wrap_next(idx_q, wr_last);
                    cnt_d = cnt_q - 14'd1;
`ifdef MEM_LOADER_CHECKSUM_EN
                    sum_d = sum_q + bus.cmd_data;
                    if (cnt_q == 14'd1) begin
                        state_d   = S_CSUM;
                        rsp_vld_d = 1'b1;
                        rsp_dat_d = sum_q + bus.cmd_data;
                    end
`else
                    if (cnt_q == 14'd1) state_d = S_HDR;
`endif
                end
            end

            S_RUN: begin
                if (idx_q == 16'd1) begin
                    state_d = S_HDR;
                end else begin
                    idx_d    = idx_q - 16'd1;
                    cpu_en_d = 1'b1;
                end
            end

            S_RD: begin
                state_d = S_CAP;
                idx_d   = wrap_next(idx_q, DMEM_LAST);
                cnt_d   = cnt_q - 14'd1;
            end

            S_CAP: begin
                rsp_dat_d = bus.rdata_ext_2;
                rsp_vld_d = 1'b1;
                state_d   = S_OUT;
            end

            S_OUT: begin
                if (bus.rsp_ready) begin
                    rsp_vld_d = 1'b0;
                    if (cnt_q != 14'd0) begin
                        state_d     = S_RD;
                        dmem_ren_d  = 1'b1;
                        dmem_addr_d = word_addr(idx_q);
                    end else begin
                        state_d = S_HDR;
                    end
                end
            end

`ifdef MEM_LOADER_CHECKSUM_EN
            S_CSUM: begin
                if (bus.rsp_ready) begin
                    rsp_vld_d = 1'b0;
                    state_d   = S_HDR;
                end
            end
`endif

            default: state_d = S_HDR;
        endcase
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state_q     <= S_HDR;
            op_q        <= 2'b00;
            cnt_q       <= 14'd0;
            idx_q       <= 16'd0;
            cpu_en_q    <= 1'b0;
            imem_wen_q  <= 1'b0;
            imem_addr_q <= 32'd0;
            imem_wdat_q <= 32'd0;
            dmem_wen_q  <= 1'b0;
            dmem_ren_q  <= 1'b0;
            dmem_addr_q <= 32'd0;
            dmem_wdat_q <= 32'd0;
            rsp_vld_q   <= 1'b0;
            rsp_dat_q   <= 32'd0;
`ifdef MEM_LOADER_CHECKSUM_EN
            sum_q       <= 32'd0;
`endif
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            cpu_en_q    <= cpu_en_d;
            imem_wen_q  <= imem_wen_d;
            imem_addr_q <= imem_addr_d;
            imem_wdat_q <= imem_wdat_d;
            dmem_wen_q  <= dmem_wen_d;
            dmem_ren_q  <= dmem_ren_d;
            dmem_addr_q <= dmem_addr_d;
            dmem_wdat_q <= dmem_wdat_d;
            rsp_vld_q   <= rsp_vld_d;
            rsp_dat_q   <= rsp_dat_d;
`ifdef MEM_LOADER_CHECKSUM_EN
            sum_q       <= sum_d;
`endif
        end
    end

    assign bus.cmd_ready   = cmd_rdy;
    assign bus.rsp_valid   = rsp_vld_q;
    assign bus.rsp_data    = rsp_dat_q;
    assign bus.busy        = (state_q != S_HDR);
    assign bus.cpu_enable  = cpu_en_q;
    assign bus.addr_ext    = imem_addr_q;
    assign bus.wdata_ext   = imem_wdat_q;
    assign bus.wen_ext     = imem_wen_q;
    assign bus.ren_ext     = 1'b0;
    assign bus.addr_ext_2  = dmem_addr_q;
    assign bus.wdata_ext_2 = dmem_wdat_q;
    assign bus.wen_ext_2   = dmem_wen_q;
    assign bus.ren_ext_2   = dmem_ren_q;

endmodule

// File: tb/tb_mem_loader.sv
// Scoreboard bench for mem_loader: negedge monitor logs strobes/responses, scenario tasks compare against expected queues.
`timescale 1ns/1ps
module tb_mem_loader;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        int          cyc;
    } wr_ev_t;

    typedef struct {
        logic [31:0] data;
        int          cyc;
    } rsp_ev_t;

    logic clk = 1'b0;
    logic arst;
    always #5 clk = ~clk;

    mem_loader_if bus ();

    mem_loader #(
        .IMEM_WORDS(512),
        .DMEM_WORDS(1024)
    ) dut (
        .clk (clk),
        .arst(arst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    wr_ev_t  obs_i[$];
    wr_ev_t  obs_d[$];
    wr_ev_t  exp_i[$];
    wr_ev_t  exp_d[$];
    rsp_ev_t obs_rsp[$];
    logic [31:0] exp_rsp[$];
    int      hs_q[$];
    int      en_q[$];

    int ncyc     = 0;
    int ren_cnt  = 0;
    int busy_cnt = 0;
    int viol     = 0;
    int unstable = 0;
    int rdy_run  = 0;
    logic        hold_vld = 1'b0;
    logic [31:0] hold_dat = 32'd0;
    wr_ev_t      mon_w;
    rsp_ev_t     mon_r;

    // Data memory seen by the loader: synchronous write, read data the cycle after ren.
    logic [31:0] dmem [0:1023];
    always @(posedge clk) begin
        if (bus.wen_ext_2) dmem[bus.addr_ext_2[11:2]] <= bus.wdata_ext_2;
        if (bus.ren_ext_2) bus.rdata_ext_2 <= dmem[bus.addr_ext_2[11:2]];
    end

    always @(negedge clk) begin
        if (!arst) begin
            if (bus.cmd_valid && bus.cmd_ready) hs_q.push_back(ncyc);
            if (bus.wen_ext) begin
                mon_w.addr = bus.addr_ext; mon_w.data = bus.wdata_ext; mon_w.cyc = ncyc;
                obs_i.push_back(mon_w);
            end
            if (bus.wen_ext_2) begin
                mon_w.addr = bus.addr_ext_2; mon_w.data = bus.wdata_ext_2; mon_w.cyc = ncyc;
                obs_d.push_back(mon_w);
            end
            if (bus.rsp_valid && bus.rsp_ready) begin
                mon_r.data = bus.rsp_data; mon_r.cyc = ncyc;
                obs_rsp.push_back(mon_r);
            end
            if (bus.cpu_enable) en_q.push_back(ncyc);
            if (bus.ren_ext_2) ren_cnt++;
            if (bus.busy) busy_cnt++;
            if (bus.cpu_enable && bus.cmd_ready) rdy_run++;
            if (bus.wen_ext && bus.wen_ext_2) viol++;
            if (bus.cpu_enable && (bus.wen_ext || bus.wen_ext_2 || bus.ren_ext_2)) viol++;
            if (bus.ren_ext) viol++;
            if (bus.rsp_valid && hold_vld && bus.rsp_data !== hold_dat) unstable++;
            hold_vld = bus.rsp_valid && !bus.rsp_ready;
            hold_dat = bus.rsp_data;
        end
        ncyc++;
    end

    task automatic drain();
        obs_i.delete(); obs_d.delete(); exp_i.delete(); exp_d.delete();
        obs_rsp.delete(); exp_rsp.delete(); hs_q.delete(); en_q.delete();
    endtask

    // Called at posedge+1; returns at posedge+1 right after the accepting edge with valid still up.
    task automatic send_word(input logic [31:0] w);
        int n;
        n = 0;
        bus.cmd_valid = 1'b1;
        bus.cmd_data  = w;
        @(negedge clk);
        while (!bus.cmd_ready && n < 200) begin @(negedge clk); n++; end
        checks++;
        if (!bus.cmd_ready) begin
            errors++;
            $display("FAIL cmd_accept_timeout: word %h not accepted, cmd_ready=%b required 1", w, bus.cmd_ready);
        end
        @(posedge clk); #1;
    endtask

    task automatic cmd_idle();
        bus.cmd_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge clk);
        while (bus.busy && n < 400) begin @(negedge clk); n++; end
        checks++;
        if (bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL idle_timeout: busy=%b required 0", bus.busy);
        end
        repeat (2) @(negedge clk);
        @(posedge clk); #1;
    endtask

    task automatic collect_rsp(input int n_words, input int stall);
        for (int k = 0; k < n_words; k++) begin
            int w;
            w = 0;
            @(negedge clk);
            while (!bus.rsp_valid && w < 100) begin @(negedge clk); w++; end
            checks++;
            if (!bus.rsp_valid) begin
                errors++;
                $display("FAIL rsp_timeout: word %0d rsp_valid=%b required 1", k, bus.rsp_valid);
            end
            repeat (stall) @(negedge clk);
            @(posedge clk); #1; bus.rsp_ready = 1'b1;
            @(posedge clk); #1; bus.rsp_ready = 1'b0;
        end
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({bus.cmd_ready, bus.rsp_valid, bus.busy, bus.cpu_enable, bus.wen_ext,
             bus.ren_ext, bus.wen_ext_2, bus.ren_ext_2} !== 8'h00) begin
            errors++;
            $display("FAIL reset_strobes: got %b required 00000000", {bus.cmd_ready, bus.rsp_valid,
                     bus.busy, bus.cpu_enable, bus.wen_ext, bus.ren_ext, bus.wen_ext_2, bus.ren_ext_2});
        end
        checks++;
        if ({bus.rsp_data, bus.addr_ext, bus.wdata_ext, bus.addr_ext_2, bus.wdata_ext_2} !== 160'd0) begin
            errors++;
            $display("FAIL reset_buses: rsp_data=%h addr_ext=%h addr_ext_2=%h required all 0",
                     bus.rsp_data, bus.addr_ext, bus.addr_ext_2);
        end
        arst = 1'b0;
        #1;
        checks++;
        if (bus.cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_release_ready: cmd_ready=%b required 1", bus.cmd_ready);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_imem_write();
        logic [31:0] w [3] = '{32'h1111_1111, 32'h2222_2222, 32'h3333_3333};
        wr_ev_t e, o;
        drain();
        for (int k = 0; k < 3; k++) begin
            e.addr = 32'h10 + 32'(4 * k); e.data = w[k]; e.cyc = 0;
            exp_i.push_back(e);
        end
        send_word(32'h0003_0004);
        for (int k = 0; k < 3; k++) send_word(w[k]);
        cmd_idle();
        wait_idle();
        checks++;
        if (obs_i.size() != 3) begin
            errors++;
            $display("FAIL imem_count: got %0d writes required 3", obs_i.size());
        end
        for (int k = 0; k < 3 && obs_i.size() > 0 && hs_q.size() > k + 1; k++) begin
            e = exp_i.pop_front();
            o = obs_i.pop_front();
            checks++;
            if (o.addr !== e.addr) begin
                errors++; $display("FAIL imem_addr[%0d]: got %h required %h", k, o.addr, e.addr);
            end
            checks++;
            if (o.data !== e.data) begin
                errors++; $display("FAIL imem_data[%0d]: got %h required %h", k, o.data, e.data);
            end
            checks++;
            if (o.cyc - hs_q[k + 1] != 1) begin
                errors++; $display("FAIL imem_latency[%0d]: got %0d required 1", k, o.cyc - hs_q[k + 1]);
            end
        end
        checks++;
        if (obs_d.size() != 0) begin
            errors++; $display("FAIL imem_no_dmem: got %0d dmem writes required 0", obs_d.size());
        end
    endtask

    task automatic test_dmem_roundtrip();
        wr_ev_t e, o;
        rsp_ev_t r0, r1;
        int ren_base;
        drain();
        e.addr = 32'hFFC; e.data = 32'hDEAD_BEEF; e.cyc = 0; exp_d.push_back(e);
        e.addr = 32'h000; e.data = 32'h0000_0005; exp_d.push_back(e);
        exp_rsp.push_back(32'hDEAD_BEEF);
        exp_rsp.push_back(32'h0000_0005);
        send_word(32'h4002_03FF);
        send_word(32'hDEAD_BEEF);
        send_word(32'h0000_0005);
        cmd_idle();
        wait_idle();
        checks++;
        if (obs_d.size() != 2) begin
            errors++; $display("FAIL dmem_count: got %0d writes required 2", obs_d.size());
        end
        while (obs_d.size() > 0 && exp_d.size() > 0) begin
            e = exp_d.pop_front();
            o = obs_d.pop_front();
            checks++;
            if (o.addr !== e.addr || o.data !== e.data) begin
                errors++;
                $display("FAIL dmem_write: got %h/%h required %h/%h", o.addr, o.data, e.addr, e.data);
            end
        end
        obs_rsp.delete();
        ren_base = ren_cnt;
        send_word(32'hC002_03FF);
        cmd_idle();
        wait_idle();
        checks++;
        if (obs_rsp.size() != 2) begin
            errors++; $display("FAIL dump_count: got %0d words required 2", obs_rsp.size());
        end else begin
            r0 = obs_rsp.pop_front();
            r1 = obs_rsp.pop_front();
            checks++;
            if (r0.data !== exp_rsp[0]) begin
                errors++; $display("FAIL dump_word0: got %h required %h", r0.data, exp_rsp[0]);
            end
            checks++;
            if (r1.data !== exp_rsp[1]) begin
                errors++; $display("FAIL dump_word1: got %h required %h", r1.data, exp_rsp[1]);
            end
            checks++;
            if (r1.cyc - r0.cyc != 3) begin
                errors++; $display("FAIL dump_rate: got %0d cycles/word required 3", r1.cyc - r0.cyc);
            end
        end
        checks++;
        if (ren_cnt - ren_base != 2) begin
            errors++; $display("FAIL dump_ren: got %0d pulses required 2", ren_cnt - ren_base);
        end
    endtask

    task automatic test_run();
        int busy_base, rdy_base, h;
        drain();
        busy_base = busy_cnt;
        rdy_base  = rdy_run;
        send_word(32'h8000_000A);
        cmd_idle();
        wait_idle();
        h = (hs_q.size() > 0) ? hs_q[0] : -100;
        checks++;
        if (en_q.size() != 10) begin
            errors++; $display("FAIL run_len: got %0d enable cycles required 10", en_q.size());
        end else begin
            checks++;
            if (en_q[0] != h + 1 || en_q[9] != h + 10) begin
                errors++;
                $display("FAIL run_window: got %0d..%0d required %0d..%0d", en_q[0], en_q[9], h + 1, h + 10);
            end
        end
        checks++;
        if (busy_cnt - busy_base != 10) begin
            errors++; $display("FAIL run_busy: got %0d cycles required 10", busy_cnt - busy_base);
        end
        checks++;
        if (rdy_run - rdy_base != 0) begin
            errors++; $display("FAIL run_ready: got %0d cycles with cmd_ready required 0", rdy_run - rdy_base);
        end
        drain();
        busy_base = busy_cnt;
        send_word(32'h8000_0000);
        cmd_idle();
        wait_idle();
        checks++;
        if (en_q.size() != 0 || busy_cnt != busy_base) begin
            errors++;
            $display("FAIL run_zero: got %0d enable / %0d busy cycles required 0/0", en_q.size(), busy_cnt - busy_base);
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] w [3];
        rsp_ev_t r;
        int ren_base, uns_base;
        drain();
        for (int k = 0; k < 3; k++) w[k] = $urandom;
        send_word(32'h4003_0008);
        for (int k = 0; k < 3; k++) send_word(w[k]);
        cmd_idle();
        wait_idle();
        drain();
        for (int k = 0; k < 3; k++) exp_rsp.push_back(w[k]);
        bus.rsp_ready = 1'b0;
        ren_base = ren_cnt;
        uns_base = unstable;
        send_word(32'hC003_0008);
        cmd_idle();
        collect_rsp(3, 5);
        wait_idle();
        bus.rsp_ready = 1'b1;
        checks++;
        if (obs_rsp.size() != 3) begin
            errors++; $display("FAIL bp_count: got %0d words required 3", obs_rsp.size());
        end
        for (int k = 0; k < 3 && obs_rsp.size() > 0; k++) begin
            r = obs_rsp.pop_front();
            checks++;
            if (r.data !== exp_rsp[k]) begin
                errors++; $display("FAIL bp_word[%0d]: got %h required %h", k, r.data, exp_rsp[k]);
            end
        end
        checks++;
        if (ren_cnt - ren_base != 3) begin
            errors++; $display("FAIL bp_ren: got %0d pulses required 3", ren_cnt - ren_base);
        end
        checks++;
        if (unstable - uns_base != 0) begin
            errors++; $display("FAIL bp_stable: got %0d data changes while held required 0", unstable - uns_base);
        end
    endtask

    task automatic test_reset_midop();
        int seen, n;
        drain();
        send_word(32'h8000_000A);
        cmd_idle();
        seen = 0;
        n = 0;
        while (seen < 4 && n < 100) begin
            @(negedge clk);
            if (bus.cpu_enable) seen++;
            n++;
        end
        #2 arst = 1'b1;
        #1;
        checks++;
        if ({bus.cpu_enable, bus.busy, bus.cmd_ready} !== 3'b000) begin
            errors++;
            $display("FAIL midop_async_drop: enable/busy/ready=%b required 000 (seen %0d enables)",
                     {bus.cpu_enable, bus.busy, bus.cmd_ready}, seen);
        end
        @(posedge clk); #1;
        arst = 1'b0;
        #1;
        checks++;
        if (bus.cmd_ready !== 1'b1 || bus.rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL midop_release: cmd_ready=%b rsp_valid=%b required 1/0", bus.cmd_ready, bus.rsp_valid);
        end
        @(posedge clk); #1;
        drain();
        send_word(32'h8000_0003);
        cmd_idle();
        wait_idle();
        checks++;
        if (en_q.size() != 3) begin
            errors++; $display("FAIL midop_next_run: got %0d enable cycles required 3", en_q.size());
        end
    endtask

`ifdef MEM_LOADER_CHECKSUM_EN
    task automatic test_checksum();
        rsp_ev_t r;
        drain();
        exp_rsp.push_back(32'h0000_0001);
        send_word(32'h4002_0000);
        send_word(32'hFFFF_FFFF);
        send_word(32'h0000_0002);
        cmd_idle();
        wait_idle();
        checks++;
        if (obs_rsp.size() != 1) begin
            errors++; $display("FAIL csum_count: got %0d words required 1", obs_rsp.size());
        end else begin
            r = obs_rsp.pop_front();
            checks++;
            if (r.data !== exp_rsp[0]) begin
                errors++; $display("FAIL csum_value: got %h required %h", r.data, exp_rsp[0]);
            end
        end
    endtask
`endif

    task automatic test_isolation();
        checks++;
        if (viol != 0) begin
            errors++; $display("FAIL strobe_isolation: got %0d violations required 0", viol);
        end
    endtask

    initial begin
        arst          = 1'b1;
        bus.cmd_valid = 1'b0;
        bus.cmd_data  = 32'd0;
        bus.rsp_ready = 1'b1;
        test_reset();
        test_imem_write();
        test_dmem_roundtrip();
        test_run();
        test_backpressure();
        test_reset_midop();
`ifdef MEM_LOADER_CHECKSUM_EN
        test_checksum();
`endif
        test_isolation();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

endmodule
